// File: rtl/yuv2rgb_pkg.sv
// Shared constants for the YUV -> RGB converter: BT.601 inverse coefficients
// (scaled by 256), rounding constant and the data-type tag encoding.
package yuv2rgb_pkg;

   localparam int PIX_WIDTH_DEF = 8;
   localparam int DTYPE_WIDTH   = 4;
   localparam int META_WIDTH    = 16;
   localparam int COEF_WIDTH    = 11;
   localparam int FRAC_BITS     = 8;
   localparam int ROUND_CONST   = 128;

   localparam logic signed [COEF_WIDTH-1:0] COEF_Y  = 11'sd298;
   localparam logic signed [COEF_WIDTH-1:0] COEF_VR = 11'sd409;
   localparam logic signed [COEF_WIDTH-1:0] COEF_UG = -11'sd100;
   localparam logic signed [COEF_WIDTH-1:0] COEF_VG = -11'sd208;
   localparam logic signed [COEF_WIDTH-1:0] COEF_UB = 11'sd516;

   typedef enum logic [DTYPE_WIDTH-1:0] {
      DTYPE_IDLE        = 4'h0,
      DTYPE_FRAME_START = 4'h1,
      DTYPE_LINE_START  = 4'h2,
      DTYPE_PIXEL       = 4'h3,
      DTYPE_LINE_END    = 4'h4,
      DTYPE_FRAME_END   = 4'h5
   } dtype_e;

endpackage

// File: rtl/yuv2rgb_chan.sv
// One output colour channel: sum of up to three products plus rounding, floor
// shift, then clamp to the unsigned pixel range (or pass bypass data through).
module yuv2rgb_chan
   import yuv2rgb_pkg::*;
#(
   parameter int PW = PIX_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic signed [PW+11:0] p0_i,
   input  logic signed [PW+11:0] p1_i,
   input  logic signed [PW+11:0] p2_i,
   input  logic                 en_i,
   input  logic [PW-1:0]        byp_i,
   output logic [PW-1:0]        pix_o
);

   localparam int SUM_W = PW + 14;
   localparam int SHR_W = PW + 6;

   logic signed [SUM_W-1:0] sum_s;
   logic signed [SHR_W-1:0] shr_d;
   logic signed [SHR_W-1:0] shr_q;
   logic                    en_q;
   logic [PW-1:0]           byp_q;
   logic [PW-1:0]           pix_d;
   logic [PW-1:0]           pix_q;

   // Sign bit set means negative; any set bit above the pixel field means overflow.
   function automatic logic [PW-1:0] clamp_pix(input logic signed [SHR_W-1:0] val);
      logic [PW-1:0] res;
      if (val[SHR_W-1]) begin
         res = '0;
      end else if (|val[SHR_W-2:PW]) begin
         res = '1;
      end else begin
         res = val[PW-1:0];
      end
      return res;
   endfunction

   // Stage 2 next state: rounded sum, floor-shifted back to integer scale.
   always_comb begin
      sum_s = SUM_W'(p0_i) + SUM_W'(p1_i) + SUM_W'(p2_i) + SUM_W'(ROUND_CONST);
      shr_d = SHR_W'(sum_s >>> FRAC_BITS);
   end

   // Stage 3 next state: clamp in convert mode, raw data in bypass mode.
   always_comb begin
      if (en_q) begin
         pix_d = clamp_pix(shr_q);
      end else begin
         pix_d = byp_q;
      end
   end

   // Stage 2 and stage 3 registers.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         shr_q <= '0;
         en_q  <= 1'b0;
         byp_q <= '0;
         pix_q <= '0;
      end else begin
         shr_q <= shr_d;
         en_q  <= en_i;
         byp_q <= byp_i;
         pix_q <= pix_d;
      end
   end

   assign pix_o = pix_q;

endmodule

// File: rtl/yuv2rgb.sv
// YUV (no offsets, signed chroma) to RGB converter: three-stage free-running
// pipeline with a same-latency bypass and delay-matched sideband signals.
module yuv2rgb
   import yuv2rgb_pkg::*;
#(
   parameter int PIXEL_WIDTH = PIX_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   enable,
   input  logic                   dvi,
   input  logic [DTYPE_WIDTH-1:0] dtypei,
   input  logic [PIXEL_WIDTH-1:0] y,
   input  logic [PIXEL_WIDTH-1:0] u,
   input  logic [PIXEL_WIDTH-1:0] v,
   input  logic [META_WIDTH-1:0]  meta_datai,
   output logic                   dvo,
   output logic [DTYPE_WIDTH-1:0] dtypeo,
   output logic [PIXEL_WIDTH-1:0] r,
   output logic [PIXEL_WIDTH-1:0] g,
   output logic [PIXEL_WIDTH-1:0] b,
   output logic [META_WIDTH-1:0]  meta_datao
);

   localparam int PROD_W = PIXEL_WIDTH + 12;

   logic signed [PROD_W-1:0] y_w_s, u_w_s, v_w_s;
   logic signed [PROD_W-1:0] yp_d, rv_d, gu_d, gv_d, bu_d;
   logic signed [PROD_W-1:0] yp_q, rv_q, gu_q, gv_q, bu_q;
   logic [PIXEL_WIDTH-1:0]   y_q, u_q, v_q;
   logic                     en_q;

   logic                     dv1_q, dv2_q, dv3_q;
   logic [DTYPE_WIDTH-1:0]   dt1_q, dt2_q, dt3_q;
   logic [META_WIDTH-1:0]    md1_q, md2_q, md3_q;

   // Stage 1 products: Y zero-extended, chroma sign-extended to product width.
   always_comb begin
      y_w_s = PROD_W'(signed'({1'b0, y}));
      u_w_s = PROD_W'(signed'(u));
      v_w_s = PROD_W'(signed'(v));
      yp_d  = y_w_s * PROD_W'(COEF_Y);
      rv_d  = v_w_s * PROD_W'(COEF_VR);
      gu_d  = u_w_s * PROD_W'(COEF_UG);
      gv_d  = v_w_s * PROD_W'(COEF_VG);
      bu_d  = u_w_s * PROD_W'(COEF_UB);
   end

   // Stage 1 registers: products, raw pixel for bypass, per-pixel mode bit.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         yp_q <= '0;
         rv_q <= '0;
         gu_q <= '0;
         gv_q <= '0;
         bu_q <= '0;
         y_q  <= '0;
         u_q  <= '0;
         v_q  <= '0;
         en_q <= 1'b0;
      end else begin
         yp_q <= yp_d;
         rv_q <= rv_d;
         gu_q <= gu_d;
         gv_q <= gv_d;
         bu_q <= bu_d;
         y_q  <= y;
         u_q  <= u;
         v_q  <= v;
         en_q <= enable;
      end
   end

   // Sideband delay line, three stages to match the pixel path.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         dv1_q <= 1'b0;
         dv2_q <= 1'b0;
         dv3_q <= 1'b0;
         dt1_q <= '0;
         dt2_q <= '0;
         dt3_q <= '0;
         md1_q <= '0;
         md2_q <= '0;
         md3_q <= '0;
      end else begin
         dv1_q <= dvi;
         dv2_q <= dv1_q;
         dv3_q <= dv2_q;
         dt1_q <= dtypei;
         dt2_q <= dt1_q;
         dt3_q <= dt2_q;
         md1_q <= meta_datai;
         md2_q <= md1_q;
         md3_q <= md2_q;
      end
   end

   yuv2rgb_chan #(.PW(PIXEL_WIDTH)) u_chan_r (
      .clk    (clk),
      .resetb (resetb),
      .p0_i   (yp_q),
      .p1_i   (rv_q),
      .p2_i   ('0),
      .en_i   (en_q),
      .byp_i  (y_q),
      .pix_o  (r)
   );

   yuv2rgb_chan #(.PW(PIXEL_WIDTH)) u_chan_g (
      .clk    (clk),
      .resetb (resetb),
      .p0_i   (yp_q),
      .p1_i   (gu_q),
      .p2_i   (gv_q),
      .en_i   (en_q),
      .byp_i  (u_q),
      .pix_o  (g)
   );

   yuv2rgb_chan #(.PW(PIXEL_WIDTH)) u_chan_b (
      .clk    (clk),
      .resetb (resetb),
      .p0_i   (yp_q),
      .p1_i   (bu_q),
      .p2_i   ('0),
      .en_i   (en_q),
      .byp_i  (v_q),
      .pix_o  (b)
   );

   assign dvo        = dv3_q;
   assign dtypeo     = dt3_q;
   assign meta_datao = md3_q;

endmodule

// File: doc/yuv2rgb.md
# yuv2rgb

Converts the imager pipeline's internal YUV representation back to RGB for display or RGB-consuming stages. The input format is Y unsigned with no +16 offset, and U/V signed two's complement with no +128 offset, all at PIXEL_WIDTH. The block sits after YUV-domain processing (noise reduction, sharpening, colour adjust) and before RGB sinks. It is a fixed-latency, free-running, three-stage pipeline: multiply, sum/round, clamp. Sideband signals are delay-matched to the pixel data, and an enable-controlled bypass takes the same latency.

## Interface
- PIXEL_WIDTH, 8, bit width of every pixel channel, in and out.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- resetb  input  1  asynchronous active-low reset.
- enable  input  1  1 = convert; 0 = bypass (r←y, g←u, b←v). Sampled per pixel at stage 1.
- dvi  input  1  input data valid.
- dtypei  input  `DTYPE_WIDTH  frame/line/pixel data type tag.
- y  input  PIXEL_WIDTH  luma, unsigned, no offset.
- u  input  PIXEL_WIDTH  Cb, signed two's complement, no offset.
- v  input  PIXEL_WIDTH  Cr, signed two's complement, no offset.
- meta_datai  input  16  per-pixel metadata.
- dvo  output  1  output data valid (dvi delayed 3 cycles).
- dtypeo  output  `DTYPE_WIDTH  dtypei delayed 3 cycles.
- r, g, b  output  PIXEL_WIDTH each  unsigned RGB, clamped to [0, 2^PIXEL_WIDTH-1].
- meta_datao  output  16  meta_datai delayed 3 cycles.

## Operation
- Coefficients are signed 11-bit, scaled by 256 (BT.601 inverse):
  - Y coefficient = 298.
  - R: Vr = 409.
  - G: Ug = -100, Vg = -208.
  - B: Ub = 516.
- Stage 1 (multiply), registered:
  - Y is zero-extended to PIXEL_WIDTH+1 signed; U and V are sign-extended.
  - Form yp = 298·Y, rv = 409·V, gu = -100·U, gv = -208·V, bu = 516·U.
  - Each product is PIXEL_WIDTH+12 signed.
  - Register raw y, u, v and the enable bit alongside the products.
- Stage 2 (sum/round), registered:
  - sR = yp+rv+128, sG = yp+gu+gv+128, sB = yp+bu+128.
  - Sums are PIXEL_WIDTH+14 signed.
  - Then arithmetic shift right by 8 (floor), giving PIXEL_WIDTH+6 signed.
- Stage 3 (clamp), registered outputs:
  - Negative → 0.
  - Greater than 2^PIXEL_WIDTH-1 → all ones.
  - Otherwise the low PIXEL_WIDTH bits.
  - If the carried enable bit is 0, output the delayed raw y/u/v instead, unmodified.
- No stall or backpressure. Every stage advances every cycle regardless of dvi; dvo qualifies data.
- Changing enable mid-stream affects exactly the pixels sampled after the change; in-flight pixels keep their own mode.

## Timing
- Latency is exactly 3 clk from an input sample to its output, in both enable modes.
- dvo, dtypeo and meta_datao are cycle-aligned with r/g/b.
- Full throughput: one pixel per clock, back-to-back dvi supported.
- Reset values: dvo=0, dtypeo=0, meta_datao=0, r=g=b=0, and all internal stage registers 0.
- Reset asserted mid-frame:
  - Outputs go to 0 asynchronously and in-flight pixels are discarded.
  - After deassertion, dvo stays 0 until a dvi=1 sample has propagated 3 cycles.

## Structure
- Coefficient constants (298, 409, -100, -208, 516) and the rounding constant 128 live in the shared include `yuv_coefs.v`, next to the forward RGB→YUV coefficients, so both directions stay consistent.
- `DTYPE_WIDTH comes from `dtypes.v`; terminal defines come from `terminals_defs.v`.
- One natural sub-module, `yuv2rgb_chan`:
  - Performs sum, round, shift and clamp for one channel.
  - Inputs are up to three signed products plus bypass data.
  - Instantiated three times, for R, G and B.
- The multiply stage stays in the top level.

## Test plan
- Reset then zeros: enable=1, Y=U=V=0, dvi=1 → 3 cycles later r=g=b=0, dvo=1.
- Mid-gray: Y=100, U=V=0 → r=g=b=116 after 3 cycles.
- Upper clamp: Y=219, U=V=0 → r=g=b=255.
- Mixed chroma: Y=0, V=127, U=0 → r=203, g=0 (negative clamp), b=0. Then Y=219, U=-128 (0x80), V=0 → r=255, g=255, b=0.
- Bypass and mode switch:
  - enable=0 with y=0x12, u=0x34, v=0x56 → r=0x12, g=0x34, b=0x56 after 3 cycles.
  - Toggling enable on alternating pixels of a back-to-back stream → each output pixel matches its own input's mode.
- Sideband and reset:
  - dvi single pulse with dtypei=frame-start tag, meta_datai=0xBEEF → dvo, dtypeo and meta_datao asserted on the same cycle, 3 clocks later.
  - resetb pulsed low while 3 pixels are in flight → all outputs 0 immediately, no dvo for those pixels afterwards.
